// File: rtl/switch_bank_reader_pkg.sv
// Shared constants for the switch bank reader slice: datapath defaults,
// register map locations and a bank-count helper.
package switch_bank_reader_pkg;

  localparam int REG_WIDTH_DEF       = 8;
  localparam int ADDR_WIDTH_DEF      = 3;
  localparam int NUM_SW_DEF          = 9;
  localparam int BANK_BASE_ADDR_DEF  = 6;
  localparam int STATUS_ADDR_DEF     = 5;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Number of REG_WIDTH-wide banks needed to hold num_sw switches.
  function automatic int banks_for(input int num_sw, input int reg_width);
    return (num_sw + reg_width - 1) / reg_width;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch bit: multi-flop synchroniser, debounce counter and the
// accepted (stable) level, plus a one-cycle pulse when the level changes.
module switch_debouncer
  import switch_bank_reader_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser shift chain; raw enters at bit 0.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      change <= 1'b0;
    end else begin
      change <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s;
        cnt    <= '0;
        change <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_bank_reader.sv
// Register read-port mux that maps debounced board switches into
// consecutive register banks plus a sticky, clear-on-read change-status
// register; all other addresses pass register-file data through.
module switch_bank_reader
  import switch_bank_reader_pkg::*;
#(
  parameter int REG_WIDTH       = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int NUM_SW          = NUM_SW_DEF,
  parameter int BANK_BASE_ADDR  = BANK_BASE_ADDR_DEF,
  parameter int STATUS_ADDR     = STATUS_ADDR_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_en,
  input  logic [REG_WIDTH-1:0]  reg_data,
  input  logic [NUM_SW-1:0]     switches,
  output logic [REG_WIDTH-1:0]  reg_out,
  output logic [NUM_SW-1:0]     sw_stable,
  output logic                  sw_changed
);

  localparam int NUM_BANKS = banks_for(NUM_SW, REG_WIDTH);
  localparam int PAD_W     = NUM_BANKS * REG_WIDTH;
  localparam int ADDR_SPAN = 1 << ADDR_WIDTH;

  // Register map sanity: status must not alias a bank, everything must be addressable.
  if (STATUS_ADDR >= BANK_BASE_ADDR && STATUS_ADDR < BANK_BASE_ADDR + NUM_BANKS) begin : g_err_overlap
    $error("switch_bank_reader: STATUS_ADDR overlaps switch bank range");
  end
  if (BANK_BASE_ADDR + NUM_BANKS > ADDR_SPAN || STATUS_ADDR >= ADDR_SPAN) begin : g_err_range
    $error("switch_bank_reader: register map exceeds address space");
  end

  logic [NUM_SW-1:0]    bit_change;
  logic [PAD_W-1:0]     banked;
  logic [PAD_W-1:0]     banked_change;
  logic [NUM_BANKS-1:0] bank_hit;
  logic [NUM_BANKS-1:0] flags;
  logic                 status_clr;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw    (switches[i]),
      .stable (sw_stable[i]),
      .change (bit_change[i])
    );
  end

  assign sw_changed = |bit_change;
  assign status_clr = rd_en && (addr == ADDR_WIDTH'(STATUS_ADDR));

  // Zero-pad stable levels and change pulses to whole banks.
  always_comb begin
    banked                     = '0;
    banked_change              = '0;
    banked[NUM_SW-1:0]         = sw_stable;
    banked_change[NUM_SW-1:0]  = bit_change;
  end

  // Reduce per-bit change pulses to one hit per bank.
  always_comb begin
    bank_hit = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_hit[b] = |banked_change[b*REG_WIDTH +: REG_WIDTH];
    end
  end

  // Sticky change flags: clear on status read, a coincident set wins.
  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= (flags & ~{NUM_BANKS{status_clr}}) | bank_hit;
  end

  // Combinational read mux over registered state.
  always_comb begin
    reg_out = reg_data;
    if (addr == ADDR_WIDTH'(STATUS_ADDR)) begin
      reg_out = REG_WIDTH'(flags);
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (addr == ADDR_WIDTH'(BANK_BASE_ADDR + b)) begin
        reg_out = banked[b*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

endmodule
